// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, branch/jump redirect flush,
// memory-busy freeze, operand forwarding select and a lost-cycle counter.
//
// state    | meaning
// RUN      | normal issue
// LU_STALL | one bubble inserted behind a load
// REDIRECT | squash the stale fetch word after a redirect
// FREEZE   | memory not ready, whole pipe held
module hazard_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [4:0]       DE_RS1_ADDR,
  input  logic [4:0]       DE_RS2_ADDR,
  input  logic             DE_RS1_USED,
  input  logic             DE_RS2_USED,
  input  logic [4:0]       DE_RD_ADDR,
  input  logic             DE_REG_WRITE,
  input  logic             DE_MEM_READ,
  input  logic             EX_REDIRECT,
  input  logic             MEM_BUSY,
  input  logic             CNT_CLR,
  output logic             PC_WRITE,
  output logic             IF_DE_EN,
  output logic             DE_EX_EN,
  output logic             EX_MEM_EN,
  output logic             IF_FLUSH,
  output logic             DE_FLUSH,
  output logic [1:0]       FWD_A_SEL,
  output logic [1:0]       FWD_B_SEL,
  output logic [1:0]       STATE,
  output logic [CNT_W-1:0] STALL_CNT
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    REDIRECT = 2'd2,
    FREEZE   = 2'd3
  } state_t;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       reg_write;
    logic       mem_read;
  } slot_t;

  typedef struct packed {
    slot_t      base;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       rs1_used;
    logic       rs2_used;
  } ex_slot_t;

  state_t   state;
  logic     pend_redirect;
  // The decode-stage fields live in the datapath IF/DE register and arrive
  // on the DE_* inputs; only their validity needs shadowing here.
  logic     de_valid;
  ex_slot_t ex;
  slot_t    mem;
  slot_t    wb;

  logic redirect;
  logic load_use;
  logic rs1_hit;
  logic rs2_hit;

  assign STATE    = state;
  assign redirect = EX_REDIRECT && ex.base.valid;

  assign rs1_hit  = DE_RS1_USED && (ex.base.rd == DE_RS1_ADDR);
  assign rs2_hit  = DE_RS2_USED && (ex.base.rd == DE_RS2_ADDR);
  assign load_use = de_valid && ex.base.valid && ex.base.mem_read &&
                    (ex.base.rd != 5'd0) && (rs1_hit || rs2_hit);

  function automatic logic [1:0] fwd_sel(
    input logic [4:0] rs,
    input logic       used,
    input slot_t      m,
    input slot_t      w
  );
    logic [1:0] sel;
    sel = 2'd0;
    if (used && (rs != 5'd0)) begin
      if (m.valid && m.reg_write && !m.mem_read && (m.rd == rs))
        sel = 2'd1;
      else if (w.valid && w.reg_write && (w.rd == rs))
        sel = 2'd2;
    end
    return sel;
  endfunction

  assign FWD_A_SEL = fwd_sel(ex.rs1, ex.rs1_used, mem, wb);
  assign FWD_B_SEL = fwd_sel(ex.rs2, ex.rs2_used, mem, wb);

  always_comb begin
    PC_WRITE  = 1'b1;
    IF_DE_EN  = 1'b1;
    DE_EX_EN  = 1'b1;
    EX_MEM_EN = 1'b1;
    IF_FLUSH  = 1'b0;
    DE_FLUSH  = 1'b0;
    if (MEM_BUSY) begin
      PC_WRITE  = 1'b0;
      IF_DE_EN  = 1'b0;
      DE_EX_EN  = 1'b0;
      EX_MEM_EN = 1'b0;
    end else if (redirect) begin
      IF_FLUSH = 1'b1;
      DE_FLUSH = 1'b1;
    end else if (state == REDIRECT) begin
      // synchronous fetch already returned the word after the branch
      IF_FLUSH = 1'b1;
    end else if (load_use) begin
      PC_WRITE = 1'b0;
      IF_DE_EN = 1'b0;
      DE_FLUSH = 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state         <= RUN;
      pend_redirect <= 1'b0;
      de_valid      <= 1'b0;
      ex            <= '0;
      mem           <= '0;
      wb            <= '0;
      STALL_CNT     <= '0;
    end else begin
      if (CNT_CLR)
        STALL_CNT <= '0;
      else if ((!PC_WRITE || IF_FLUSH) && (STALL_CNT != {CNT_W{1'b1}}))
        STALL_CNT <= STALL_CNT + 1'b1;

      if (MEM_BUSY) begin
        state <= FREEZE;
        if ((state == REDIRECT) || redirect)
          pend_redirect <= 1'b1;
      end else if (state == FREEZE) begin
        state         <= pend_redirect ? REDIRECT : RUN;
        pend_redirect <= 1'b0;
      end else if (redirect) begin
        state <= REDIRECT;
      end else if (load_use) begin
        state <= LU_STALL;
      end else begin
        state <= RUN;
      end

      if (!MEM_BUSY) begin
        wb  <= mem;
        mem <= ex.base;
        if (DE_FLUSH)
          ex <= '0;
        else
          ex <= {de_valid, DE_RD_ADDR, DE_REG_WRITE, DE_MEM_READ,
                 DE_RS1_ADDR, DE_RS2_ADDR, DE_RS1_USED, DE_RS2_USED};
        if (IF_DE_EN)
          de_valid <= !IF_FLUSH;
      end
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: a hand-computed cycle table pushed through a
// scoreboard queue, then saturation, clear and async-reset sequences.
module tb_hazard_ctrl;

  logic        clk;
  logic        rst;
  logic [4:0]  de_rs1_addr;
  logic [4:0]  de_rs2_addr;
  logic        de_rs1_used;
  logic        de_rs2_used;
  logic [4:0]  de_rd_addr;
  logic        de_reg_write;
  logic        de_mem_read;
  logic        ex_redirect;
  logic        mem_busy;
  logic        cnt_clr;

  logic        pc_write, if_de_en, de_ex_en, ex_mem_en, if_flush, de_flush;
  logic [1:0]  fwd_a_sel, fwd_b_sel, state;
  logic [15:0] stall_cnt;

  logic        pc_write4, if_de_en4, de_ex_en4, ex_mem_en4, if_flush4, de_flush4;
  logic [1:0]  fwd_a_sel4, fwd_b_sel4, state4;
  logic [3:0]  stall_cnt4;

  hazard_ctrl dut (
    .CLK(clk), .RST(rst),
    .DE_RS1_ADDR(de_rs1_addr), .DE_RS2_ADDR(de_rs2_addr),
    .DE_RS1_USED(de_rs1_used), .DE_RS2_USED(de_rs2_used),
    .DE_RD_ADDR(de_rd_addr), .DE_REG_WRITE(de_reg_write), .DE_MEM_READ(de_mem_read),
    .EX_REDIRECT(ex_redirect), .MEM_BUSY(mem_busy), .CNT_CLR(cnt_clr),
    .PC_WRITE(pc_write), .IF_DE_EN(if_de_en), .DE_EX_EN(de_ex_en), .EX_MEM_EN(ex_mem_en),
    .IF_FLUSH(if_flush), .DE_FLUSH(de_flush),
    .FWD_A_SEL(fwd_a_sel), .FWD_B_SEL(fwd_b_sel),
    .STATE(state), .STALL_CNT(stall_cnt)
  );

  hazard_ctrl #(.CNT_W(4)) dut4 (
    .CLK(clk), .RST(rst),
    .DE_RS1_ADDR(de_rs1_addr), .DE_RS2_ADDR(de_rs2_addr),
    .DE_RS1_USED(de_rs1_used), .DE_RS2_USED(de_rs2_used),
    .DE_RD_ADDR(de_rd_addr), .DE_REG_WRITE(de_reg_write), .DE_MEM_READ(de_mem_read),
    .EX_REDIRECT(ex_redirect), .MEM_BUSY(mem_busy), .CNT_CLR(cnt_clr),
    .PC_WRITE(pc_write4), .IF_DE_EN(if_de_en4), .DE_EX_EN(de_ex_en4), .EX_MEM_EN(ex_mem_en4),
    .IF_FLUSH(if_flush4), .DE_FLUSH(de_flush4),
    .FWD_A_SEL(fwd_a_sel4), .FWD_B_SEL(fwd_b_sel4),
    .STATE(state4), .STALL_CNT(stall_cnt4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ctl = {PC_WRITE, IF_DE_EN, DE_EX_EN, EX_MEM_EN, IF_FLUSH, DE_FLUSH}
  localparam logic [5:0] CN = 6'b111100;
  localparam logic [5:0] CL = 6'b001101;
  localparam logic [5:0] CR = 6'b111111;
  localparam logic [5:0] CF = 6'b111110;
  localparam logic [5:0] CZ = 6'b000000;

  typedef struct {
    logic [4:0]  rs1, rs2;
    logic        u1, u2;
    logic [4:0]  rd;
    logic        rw, mr, redir, busy, clr;
    logic [5:0]  ctl;
    logic [1:0]  fa, fb, st;
    logic [15:0] cnt;
  } vec_t;

  vec_t         tbl [29];
  logic [27:0]  sb_q [$];
  int           n_vec = 0;
  int           n_err = 0;

  function automatic vec_t mk(input int rs1, input int rs2, input int u1, input int u2,
                              input int rd, input int rw, input int mr,
                              input int redir, input int busy, input int clr,
                              input int ctl, input int fa, input int fb,
                              input int st, input int cnt);
    vec_t v;
    v.rs1 = 5'(rs1);  v.rs2 = 5'(rs2);  v.u1 = 1'(u1);  v.u2 = 1'(u2);
    v.rd = 5'(rd);    v.rw = 1'(rw);    v.mr = 1'(mr);
    v.redir = 1'(redir); v.busy = 1'(busy); v.clr = 1'(clr);
    v.ctl = 6'(ctl);  v.fa = 2'(fa);    v.fb = 2'(fb);  v.st = 2'(st);
    v.cnt = 16'(cnt);
    return v;
  endfunction

  function automatic logic [27:0] outs();
    return {pc_write, if_de_en, de_ex_en, ex_mem_en, if_flush, de_flush,
            fwd_a_sel, fwd_b_sel, state, stall_cnt};
  endfunction

  task automatic cmp(input string name, input logic [27:0] g, input logic [27:0] e);
    n_vec++;
    if (g !== e) begin
      n_err++;
      $display("FAIL %s: got ctl=%b fa=%0d fb=%0d st=%0d cnt=%0d, expected ctl=%b fa=%0d fb=%0d st=%0d cnt=%0d",
               name, g[27:22], g[21:20], g[19:18], g[17:16], g[15:0],
               e[27:22], e[21:20], e[19:18], e[17:16], e[15:0]);
    end
  endtask

  task automatic cmp4(input string name, input logic [3:0] g, input logic [3:0] e);
    n_vec++;
    if (g !== e) begin
      n_err++;
      $display("FAIL %s: got cnt=%0d, expected cnt=%0d", name, g, e);
    end
  endtask

  task automatic apply(input vec_t v, input string name);
    logic [27:0] e;
    de_rs1_addr  = v.rs1;  de_rs2_addr = v.rs2;
    de_rs1_used  = v.u1;   de_rs2_used = v.u2;
    de_rd_addr   = v.rd;   de_reg_write = v.rw;  de_mem_read = v.mr;
    ex_redirect  = v.redir; mem_busy = v.busy;   cnt_clr = v.clr;
    sb_q.push_back({v.ctl, v.fa, v.fb, v.st, v.cnt});
    @(negedge clk);
    e = sb_q.pop_front();
    cmp(name, outs(), e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // nop = no sources used, rd=x0, no write
    tbl[0]  = mk(1, 0, 1, 0, 5, 1, 1,  0, 0, 0, CN, 0, 0, 0, 0);  // lw x5, DE not yet valid
    tbl[1]  = mk(1, 0, 1, 0, 5, 1, 1,  0, 0, 0, CN, 0, 0, 0, 0);  // lw x5
    tbl[2]  = mk(5, 7, 1, 1, 6, 1, 0,  0, 0, 0, CL, 0, 0, 0, 0);  // add x6,x5,x7 -> load-use
    tbl[3]  = mk(5, 7, 1, 1, 6, 1, 0,  0, 0, 0, CN, 0, 0, 1, 1);
    tbl[4]  = mk(0, 0, 1, 0, 3, 1, 0,  0, 0, 0, CN, 2, 0, 0, 1);  // add in EX, lw in WB
    tbl[5]  = mk(3, 3, 1, 1, 4, 1, 0,  0, 0, 0, CN, 0, 0, 0, 1);  // sub x4,x3,x3
    tbl[6]  = mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, CN, 1, 1, 0, 1);  // sub in EX, addi in MEM
    tbl[7]  = mk(2, 0, 1, 0, 0, 1, 1,  0, 0, 0, CN, 0, 0, 0, 1);  // lw x0
    tbl[8]  = mk(0, 0, 1, 1, 8, 1, 0,  0, 0, 0, CN, 0, 0, 0, 1);  // reader of x0, no stall
    tbl[9]  = mk(0, 0, 0, 0, 0, 0, 0,  1, 0, 0, CR, 0, 0, 0, 1);  // redirect
    tbl[10] = mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, CF, 0, 0, 2, 2);
    tbl[11] = mk(0, 0, 0, 0, 0, 0, 0,  1, 0, 0, CN, 0, 0, 0, 3);  // redirect with EX invalid
    tbl[12] = mk(1, 0, 1, 0, 9, 1, 1,  0, 0, 0, CN, 0, 0, 0, 3);  // lw x9
    tbl[13] = mk(9, 0, 1, 1, 10, 1, 0, 1, 0, 0, CR, 0, 0, 0, 3);  // redirect + load-use
    tbl[14] = mk(0, 0, 0, 0, 0, 0, 0,  0, 1, 0, CZ, 0, 0, 2, 4);  // busy in REDIRECT
    tbl[15] = mk(0, 0, 0, 0, 0, 0, 0,  0, 1, 0, CZ, 0, 0, 3, 5);
    tbl[16] = mk(0, 0, 0, 0, 0, 0, 0,  0, 1, 0, CZ, 0, 0, 3, 6);
    tbl[17] = mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, CN, 0, 0, 3, 7);  // release
    tbl[18] = mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, CF, 0, 0, 2, 7);  // replayed squash
    tbl[19] = mk(0, 0, 1, 0, 11, 1, 0, 0, 0, 0, CN, 0, 0, 0, 8);
    tbl[20] = mk(0, 0, 1, 0, 11, 1, 0, 0, 0, 0, CN, 0, 0, 0, 8);  // addi x11
    tbl[21] = mk(11, 11, 1, 1, 12, 1, 0, 0, 0, 0, CN, 0, 0, 0, 8); // add x12,x11,x11
    tbl[22] = mk(0, 0, 0, 0, 0, 0, 0,  0, 1, 0, CZ, 1, 1, 0, 8);  // freeze with forwarding live
    tbl[23] = mk(0, 0, 0, 0, 0, 0, 0,  0, 1, 0, CZ, 1, 1, 3, 9);
    tbl[24] = mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, CN, 1, 1, 3, 10);
    tbl[25] = mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 1, CN, 0, 0, 0, 10); // clear
    tbl[26] = mk(0, 0, 0, 0, 0, 0, 0,  0, 1, 1, CZ, 0, 0, 0, 0);  // clear beats increment
    tbl[27] = mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, CN, 0, 0, 3, 0);
    tbl[28] = mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, CN, 0, 0, 0, 0);

    rst = 1'b1;
    de_rs1_addr = '0; de_rs2_addr = '0; de_rs1_used = 1'b0; de_rs2_used = 1'b0;
    de_rd_addr = '0; de_reg_write = 1'b0; de_mem_read = 1'b0;
    ex_redirect = 1'b0; mem_busy = 1'b0; cnt_clr = 1'b0;
    @(negedge clk);
    cmp("reset", outs(), {CN, 2'd0, 2'd0, 2'd0, 16'd0});
    step();
    rst = 1'b0;

    for (int i = 0; i < 29; i++) begin
      apply(tbl[i], $sformatf("vec%0d", i));
      step();
    end

    // 20 frozen cycles: 16-bit counter reaches 20, 4-bit one sticks at 15
    for (int i = 0; i < 20; i++) begin
      apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, CZ, 0, 0, (i == 0) ? 0 : 3, i),
            $sformatf("busy%0d", i));
      step();
    end
    apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, CN, 0, 0, 3, 20), "sat_clr");
    cmp4("sat4", stall_cnt4, 4'd15);
    step();
    apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, CN, 0, 0, 0, 0), "after_clr");
    cmp4("clr4", stall_cnt4, 4'd0);
    step();

    // load-use, then async reset while in LU_STALL
    apply(mk(1, 0, 1, 0, 5, 1, 1, 0, 0, 0, CN, 0, 0, 0, 0), "lw_x5");
    step();
    apply(mk(5, 7, 1, 1, 6, 1, 0, 0, 0, 0, CL, 0, 0, 0, 0), "lu2");
    step();
    cmp("lu_stall_state", outs(), {CN, 2'd0, 2'd0, 2'd1, 16'd1});
    #2 rst = 1'b1;
    #1 cmp("async_rst", outs(), {CN, 2'd0, 2'd0, 2'd0, 16'd0});
    cmp4("async_rst4", stall_cnt4, 4'd0);
    rst = 1'b0;
    apply(mk(5, 7, 1, 1, 6, 1, 0, 0, 0, 0, CN, 0, 0, 0, 0), "post_rst");
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
